ps2_kbd_rx: RTL and testbench
=============================

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples required to accept a new level.
REQ-002 SHALL have parameter TIMEOUT, default 100000: clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two: number of completed codes buffered.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-007 ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-008 out_code  output  16  {prefix, scan byte}; prefix 8'hE0 if extended, else 8'h00.
REQ-009 out_brk  output  1  1 = key release (F0 seen), 0 = key press.
REQ-010 out_valid  output  1  FIFO head holds a valid code.
REQ-011 out_ready  input  1  consumer accepts the head when out_valid && out_ready.
REQ-012 err_frame  output  1  one-cycle pulse on bad start/stop bit, or on timeout.
REQ-013 err_parity  output  1  one-cycle pulse on odd-parity failure.
REQ-014 err_ovf  output  1  one-cycle pulse when a code is dropped because the FIFO is full.

Function
REQ-015 SHALL pass ps2_clk and ps2_data through 2-FF synchronizers, then filter ps2_clk per FILTER_LEN; falling edge = filtered level 1->0.
REQ-016 SHALL sample synchronized ps2_data on each filtered falling edge.
REQ-017 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP; IDLE->DATA on sampled 0; an IDLE sample of 1 raises err_frame and stays in IDLE.
REQ-018 DATA SHALL shift 8 bits LSB first, then go to PARITY; PARITY->STOP unconditionally; STOP->IDLE always.
REQ-019 Byte SHALL complete on a STOP sample of 1 with good parity; a STOP sample of 0 raises err_frame and discards the byte.
REQ-020 Timeout counter SHALL clear on every falling edge and on IDLE; reaching TIMEOUT-1 outside IDLE forces IDLE, raises err_frame, and clears prefix flags.
REQ-021 Assembler behaviour per byte:
- 8'hE0 sets ext, no output.
- 8'hF0 sets brk, no output.
- Any other byte pushes {ext?E0:00, byte} with brk into the FIFO, then clears ext and brk.
REQ-022 A push and a pop in the same cycle SHALL both take effect when the FIFO is non-empty, including when full.
REQ-023 A push while full with no pop SHALL drop the new code, pulse err_ovf, and leave FIFO contents unchanged.
REQ-024 out_code/out_brk SHALL present the FIFO head combinationally from registered storage.
REQ-025 When out_valid=0, out_code and out_brk SHALL read 0.
REQ-026 Latency from the filtered falling edge of the stop bit to out_valid=1 (FIFO previously empty) SHALL be 2 clk cycles.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy count width is clog2(FIFO_DEPTH)+1.

Reset
REQ-028 rst SHALL asynchronously force FSM=IDLE, bit and timeout counters=0, ext=brk=0, FIFO empty, all outputs 0, and synchronizers/filter to 1 (bus idle).
REQ-029 A frame in progress at reset assertion SHALL be discarded with no error pulse.

Configuration
REQ-030 Macro PS2_PARITY_CHECK_EN defined: failing frames are discarded and err_parity pulses.
REQ-031 Macro PS2_PARITY_CHECK_EN undefined: the parity bit is sampled but ignored, and err_parity is tied to 0.

Structure
REQ-032 Shared package ps2_pkg SHALL hold the frame-state enum and constants SC_EXT=8'hE0 and SC_BRK=8'hF0.
REQ-033 FIFO SHALL be a sub-module named ps2_code_fifo, parameterized by width 17 and FIFO_DEPTH.

Verification
REQ-034 Frame 0x1C, odd parity bit 0, stop 1 -> out_code=16'h001C, out_brk=0, out_valid 2 cycles after the stop edge.
REQ-035 Frames E0,F0,75 -> exactly one output: out_code=16'hE075, out_brk=1.
REQ-036 Frame 0x1C with parity bit 1 -> with macro: err_parity pulse, no output; without macro: 16'h001C delivered.
REQ-037 Five makes (0x16,0x1E,0x26,0x25,0x2E) with out_ready=0 -> first four held in order, err_ovf pulses once, 0x2E lost.
REQ-038 Stop ps2_clk after 4 data bits for TIMEOUT cycles -> err_frame pulse, FSM back in IDLE, next frame 0x1C decodes correctly.
REQ-039 Assert rst mid-frame (bit 5) -> outputs 0 immediately, no error pulse, next full frame 0x1C decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;
   localparam int         CODE_W = 17;

   typedef struct packed {
      logic        brk;
      logic [15:0] code;
   } code_entry_t;

   // Odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// Small synchronous FIFO for decoded key codes; head is shown combinationally.
module ps2_code_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             ovf
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    count;
   logic             full, do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign valid   = (count != '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && valid;
   // A pop frees the head slot this cycle, so a push while full still lands.
   assign do_push = push && (!full || do_pop);
   assign ovf     = push && full && !do_pop;
   assign dout    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, frame FSM, prefix assembler, code FIFO.
// Define PS2_PARITY_CHECK_EN to discard bad-parity frames and pulse err_parity.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 100000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] out_code,
   output logic        out_brk,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        err_frame,
   output logic        err_parity,
   output logic        err_ovf
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [1:0] clk_sync, data_sync;
   logic       clk_s, data_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];

   logic [FW-1:0] flt_cnt;
   logic          flt_lvl;
   logic          fall;

   // flt_cnt counts consecutive samples disagreeing with the accepted level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flt_cnt <= '0;
         flt_lvl <= 1'b1;
         fall    <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_s == flt_lvl) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            flt_lvl <= clk_s;
            flt_cnt <= '0;
            fall    <= flt_lvl;
         end else begin
            flt_cnt <= flt_cnt + FW'(1);
         end
      end
   end

   frame_state_t  state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [7:0]    rx_byte;
   logic [TW-1:0] to_cnt;
   logic          to_hit;
   logic          byte_done;
   logic          perr_q;
`ifdef PS2_PARITY_CHECK_EN
   logic          par_bit;
`endif

   assign to_hit = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx_byte   <= '0;
         to_cnt    <= '0;
         byte_done <= 1'b0;
         err_frame <= 1'b0;
         perr_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         byte_done <= 1'b0;
         err_frame <= 1'b0;
         perr_q    <= 1'b0;
         if (state == IDLE || fall) to_cnt <= '0;
         else                       to_cnt <= to_cnt + TW'(1);

         if (to_hit) begin
            state     <= IDLE;
            err_frame <= 1'b1;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  if (data_s) begin
                     err_frame <= 1'b1;
                  end else begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shreg   <= {data_s, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  par_bit <= data_s;
`endif
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (!data_s) begin
                     err_frame <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                  end else if (!odd_parity_ok(shreg, par_bit)) begin
                     perr_q <= 1'b1;
`endif
                  end else begin
                     byte_done <= 1'b1;
                     rx_byte   <= shreg;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef PS2_PARITY_CHECK_EN
   assign err_parity = perr_q;
`else
   assign err_parity = 1'b0;
   logic unused_perr;
   assign unused_perr = perr_q;
`endif

   logic        ext, brk;
   logic        push, ovf;
   code_entry_t push_entry;
   code_entry_t head;
   logic [CODE_W-1:0] head_raw;

   assign push = byte_done && (rx_byte != SC_EXT) && (rx_byte != SC_BRK);

   always_comb begin
      push_entry.brk  = brk;
      push_entry.code = {(ext ? SC_EXT : 8'h00), rx_byte};
   end

   // Prefix flags survive bad frames; only a timeout or a delivered code clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (to_hit) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (byte_done) begin
         if (rx_byte == SC_EXT) begin
            ext <= 1'b1;
         end else if (rx_byte == SC_BRK) begin
            brk <= 1'b1;
         end else begin
            ext <= 1'b0;
            brk <= 1'b0;
         end
      end
   end

   ps2_code_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_entry),
      .pop   (out_ready),
      .dout  (head_raw),
      .valid (out_valid),
      .ovf   (ovf)
   );

   assign head     = head_raw;
   assign out_code = head.code;
   assign out_brk  = head.brk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_ovf <= 1'b0;
      else     err_ovf <= ovf;
   end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: table vectors, corner sequences, random frames vs model.
module tb_ps2_kbd_rx;

   localparam int FILTER_LEN = 4;
   localparam int TIMEOUT    = 300;
   localparam int FIFO_DEPTH = 4;
   localparam int HALF       = 10;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        out_ready = 1'b0;
   logic [15:0] out_code;
   logic        out_brk, out_valid, err_frame, err_parity, err_ovf;

   int vectors = 0, miscompares = 0;
   int n_ferr = 0, n_perr = 0, n_ovf = 0, idle_bad = 0;
   logic [16:0] got[$];

   always #5 clk = ~clk;

   ps2_kbd_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .out_code   (out_code),
      .out_brk    (out_brk),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .err_frame  (err_frame),
      .err_parity (err_parity),
      .err_ovf    (err_ovf)
   );

   always @(negedge clk) begin
      if (err_frame)  n_ferr++;
      if (err_parity) n_perr++;
      if (err_ovf)    n_ovf++;
      if (!out_valid && (out_code != 16'h0 || out_brk)) idle_bad++;
      if (out_valid && out_ready) got.push_back({out_brk, out_code});
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 out_ready = v;
   endtask

   task automatic send_bit(input logic v);
      @(negedge clk);
      ps2_data = v;
      wait_n(HALF);
      ps2_clk = 1'b0;
      wait_n(2 * HALF);
      ps2_clk = 1'b1;
      wait_n(HALF);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic par;
      par = ~(^b) ^ bad_par;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(par);
      send_bit(~bad_stop);
      @(negedge clk);
      ps2_data = 1'b1;
   endtask

   typedef struct {
      string           name;
      logic [2:0][7:0] b;
      int              nb;
      bit              bad_par;
      bit              bad_stop;
      int              exp_n;
      logic [15:0]     exp_code;
      logic            exp_brk;
      int              exp_ferr;
      int              exp_perr;
   } vec_t;

   function automatic vec_t mk(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int nb, input bit bp, input bit bs,
                               input int en, input logic [15:0] ec, input logic eb,
                               input int ef, input int ep);
      vec_t v;
      v.name = nm; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.nb = nb;
      v.bad_par = bp; v.bad_stop = bs; v.exp_n = en; v.exp_code = ec;
      v.exp_brk = eb; v.exp_ferr = ef; v.exp_perr = ep;
      return v;
   endfunction

   vec_t tbl[8];

   initial begin
      int f0, p0, o0;
      logic [15:0] ov_codes[5];

      tbl[0] = mk("make_1C",    8'h1C, 8'h00, 8'h00, 1, 0, 0, 1, 16'h001C, 1'b0, 0, 0);
      tbl[1] = mk("ext_brk_75", 8'hE0, 8'hF0, 8'h75, 3, 0, 0, 1, 16'hE075, 1'b1, 0, 0);
      tbl[2] = mk("brk_1C",     8'hF0, 8'h1C, 8'h00, 2, 0, 0, 1, 16'h001C, 1'b1, 0, 0);
      tbl[3] = mk("ext_1F",     8'hE0, 8'h1F, 8'h00, 2, 0, 0, 1, 16'hE01F, 1'b0, 0, 0);
      if (PAR_EN)
         tbl[4] = mk("par_1C",  8'h1C, 8'h00, 8'h00, 1, 1, 0, 0, 16'h001C, 1'b0, 0, 1);
      else
         tbl[4] = mk("par_1C",  8'h1C, 8'h00, 8'h00, 1, 1, 0, 1, 16'h001C, 1'b0, 0, 0);
      tbl[5] = mk("stop_5A",    8'h5A, 8'h00, 8'h00, 1, 0, 1, 0, 16'h0000, 1'b0, 1, 0);
      tbl[6] = mk("brk_ext_12", 8'hF0, 8'hE0, 8'h12, 3, 0, 0, 1, 16'hE012, 1'b1, 0, 0);
      tbl[7] = mk("code_00",    8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 16'h0000, 1'b0, 0, 0);

      // reset state
      wait_n(3);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_code", out_code, 0);
      check("rst_brk", out_brk, 0);
      check("rst_errs", {err_frame, err_parity, err_ovf}, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_n(10);
      set_ready(1'b1);

      // table-driven frames
      foreach (tbl[v]) begin
         got.delete();
         f0 = n_ferr; p0 = n_perr;
         for (int k = 0; k < tbl[v].nb; k++)
            send_frame(tbl[v].b[k], (k == tbl[v].nb - 1) && tbl[v].bad_par,
                       (k == tbl[v].nb - 1) && tbl[v].bad_stop);
         wait_n(20);
         check({tbl[v].name, "_count"}, got.size(), tbl[v].exp_n);
         if (tbl[v].exp_n > 0 && got.size() > 0) begin
            check({tbl[v].name, "_code"}, got[0][15:0], tbl[v].exp_code);
            check({tbl[v].name, "_brk"}, got[0][16], tbl[v].exp_brk);
         end
         check({tbl[v].name, "_ferr"}, n_ferr - f0, tbl[v].exp_ferr);
         check({tbl[v].name, "_perr"}, n_perr - p0, tbl[v].exp_perr);
      end

      // start bit of 1 is rejected, then a good frame still decodes
      got.delete();
      f0 = n_ferr;
      send_bit(1'b1);
      wait_n(20);
      check("badstart_ferr", n_ferr - f0, 1);
      check("badstart_count", got.size(), 0);
      send_frame(8'h1C, 0, 0);
      wait_n(20);
      check("badstart_next", got.size() > 0 ? got[0] : 17'h1FFFF, {1'b0, 16'h001C});

      // latency: out_valid exactly 2 cycles after the filtered stop-bit fall
      set_ready(1'b0);
      got.delete();
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(i >= 2 && i <= 4);
      send_bit(1'b0);
      @(negedge clk);
      ps2_data = 1'b1;
      wait_n(HALF);
      ps2_clk = 1'b0;
      for (int k = 1; k <= FILTER_LEN + 4; k++) begin
         @(negedge clk);
         if (k == FILTER_LEN + 3) check("lat_before", out_valid, 0);
         if (k == FILTER_LEN + 4) begin
            check("lat_valid", out_valid, 1);
            check("lat_code", out_code, 16'h001C);
            check("lat_brk", out_brk, 0);
         end
      end
      wait_n(2 * HALF - (FILTER_LEN + 4));
      ps2_clk = 1'b1;
      wait_n(HALF);
      set_ready(1'b1);
      wait_n(5);
      check("lat_drain", got.size(), 1);

      // overflow: five makes with no consumer
      set_ready(1'b0);
      got.delete();
      o0 = n_ovf;
      ov_codes = '{16'h0016, 16'h001E, 16'h0026, 16'h0025, 16'h002E};
      for (int i = 0; i < 5; i++) send_frame(ov_codes[i][7:0], 0, 0);
      wait_n(20);
      check("ovf_pulses", n_ovf - o0, 1);
      check("ovf_valid", out_valid, 1);
      check("ovf_head", out_code, 16'h0016);
      set_ready(1'b1);
      wait_n(10);
      check("ovf_count", got.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < got.size()) check($sformatf("ovf_item%0d", i), got[i], {1'b0, ov_codes[i]});

      // timeout mid-frame clears the pending E0 prefix too
      got.delete();
      f0 = n_ferr;
      send_frame(8'hE0, 0, 0);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(i >= 2);
      wait_n(TIMEOUT + 100);
      check("to_ferr", n_ferr - f0, 1);
      check("to_count", got.size(), 0);
      send_frame(8'h1C, 0, 0);
      wait_n(20);
      check("to_next_count", got.size(), 1);
      check("to_next", got.size() > 0 ? got[0] : 17'h1FFFF, {1'b0, 16'h001C});

      // reset in the middle of a frame with a code pending
      set_ready(1'b0);
      got.delete();
      send_frame(8'h1C, 0, 0);
      wait_n(20);
      check("mid_rst_pre_valid", out_valid, 1);
      f0 = n_ferr; p0 = n_perr; o0 = n_ovf;
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(i[0]);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_code", out_code, 0);
      check("mid_rst_brk", out_brk, 0);
      ps2_data = 1'b1;
      wait_n(5);
      rst = 1'b0;
      wait_n(20);
      check("mid_rst_errs", (n_ferr - f0) + (n_perr - p0) + (n_ovf - o0), 0);
      set_ready(1'b1);
      send_frame(8'h1C, 0, 0);
      wait_n(20);
      check("mid_rst_next_count", got.size(), 1);
      check("mid_rst_next", got.size() > 0 ? got[0] : 17'h1FFFF, {1'b0, 16'h001C});

      // random byte stream against a prefix-level reference model
      begin
         logic [16:0] expq[$];
         bit mext, mbrk, done;
         int ef, ep;
         mext = 0; mbrk = 0; done = 0; ef = 0; ep = 0;
         got.delete();
         f0 = n_ferr; p0 = n_perr;
         fork
            begin
               for (int i = 0; i < 30; i++) begin
                  logic [7:0] b;
                  bit bp, bs;
                  int r;
                  r = $urandom_range(0, 5);
                  if (r == 0 && i != 29)      b = 8'hE0;
                  else if (r == 1 && i != 29) b = 8'hF0;
                  else begin
                     b = 8'($urandom_range(0, 255));
                     while (b == 8'hE0 || b == 8'hF0) b = 8'($urandom_range(0, 255));
                  end
                  bp = (i != 29) && ($urandom_range(0, 7) == 0);
                  bs = (i != 29) && ($urandom_range(0, 9) == 0);
                  if (bs) ef++;
                  else if (bp && PAR_EN) ep++;
                  else if (b == 8'hE0) mext = 1;
                  else if (b == 8'hF0) mbrk = 1;
                  else begin
                     expq.push_back({mbrk, (mext ? 8'hE0 : 8'h00), b});
                     mext = 0; mbrk = 0;
                  end
                  send_frame(b, bp, bs);
               end
               wait_n(30);
               done = 1;
            end
            begin
               while (!done) begin
                  @(posedge clk);
                  #1 out_ready = ($urandom_range(0, 3) != 0);
               end
            end
         join
         set_ready(1'b1);
         wait_n(10);
         check("rand_count", got.size(), expq.size());
         for (int i = 0; i < expq.size(); i++)
            if (i < got.size()) check($sformatf("rand_item%0d", i), got[i], expq[i]);
         check("rand_ferr", n_ferr - f0, ef);
         check("rand_perr", n_perr - p0, ep);
      end

      check("idle_outputs_zero", idle_bad, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
